// File: rtl/pac_fifo_pkg.sv
// Shared defaults and width helpers for the multi-channel request FIFO.
package pac_fifo_pkg;

  localparam int unsigned DefWidth = 640;
  localparam int unsigned DefDepth = 32;
  localparam int unsigned DefNumCh = 4;

  // Occupancy needs one extra bit so that a full channel (count == depth) is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/multi_channel_request_fifo_if.sv
// Push/pop bus of the multi-channel request FIFO; the slave modport is the FIFO side.
interface multi_channel_request_fifo_if #(
  parameter int unsigned WIDTH  = pac_fifo_pkg::DefWidth,
  parameter int unsigned DEPTH  = pac_fifo_pkg::DefDepth,
  parameter int unsigned NUM_CH = pac_fifo_pkg::DefNumCh
);
  localparam int unsigned CntW = pac_fifo_pkg::cnt_width(DEPTH);
  localparam int unsigned IdxW = pac_fifo_pkg::idx_width(NUM_CH);

  logic [NUM_CH-1:0]            push_en;
  logic [NUM_CH-1:0][WIDTH-1:0] data_in;
  logic [NUM_CH-1:0]            full;
  logic [NUM_CH-1:0]            almost_full;
  logic [NUM_CH-1:0][CntW-1:0]  count;
  logic [NUM_CH-1:0]            overflow;
  logic                         clear_en;
  logic                         pop_en;
  logic [WIDTH-1:0]             data_out;
  logic [IdxW-1:0]              out_ch;
  logic                         empty;

  modport master (
    output push_en, data_in, clear_en, pop_en,
    input  full, almost_full, count, overflow, data_out, out_ch, empty
  );

  modport slave (
    input  push_en, data_in, clear_en, pop_en,
    output full, almost_full, count, overflow, data_out, out_ch, empty
  );

endinterface

// File: rtl/request_fifo_channel.sv
// One show-ahead request channel: storage, wrap-around pointers, occupancy and flags.
module request_fifo_channel
  import pac_fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = DefWidth,
  parameter int unsigned DEPTH        = DefDepth,
  parameter int unsigned AFULL_THRESH = DEPTH - 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear_en,
  input  logic                          push_en,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          pop_en,
  output logic [WIDTH-1:0]              head,
  output logic                          not_empty,
  output logic                          full,
  output logic                          almost_full,
  output logic                          overflow,
  output logic [cnt_width(DEPTH)-1:0]   count
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push_ok, pop_ok;

  // Flags come from registered occupancy only.
  assign full        = (count_q == CntW'(DEPTH));
  assign almost_full = (count_q >= CntW'(AFULL_THRESH));
  assign not_empty   = (count_q != '0);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign head        = mem_q[rd_ptr_q];

  assign push_ok = push_en & ~full & ~clear_en;
  assign pop_ok  = pop_en & not_empty & ~clear_en;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_en) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (push_en && full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/multi_channel_request_fifo.sv
// Per-channel request FIFOs merged onto one show-ahead output by a round-robin selector.
module multi_channel_request_fifo
  import pac_fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = DefWidth,
  parameter int unsigned DEPTH        = DefDepth,
  parameter int unsigned NUM_CH       = DefNumCh,
  parameter int unsigned AFULL_THRESH = DEPTH - 4
) (
  input logic                        clk,
  input logic                        reset_n,
  multi_channel_request_fifo_if.slave bus
);
  localparam int unsigned IdxW = idx_width(NUM_CH);

  logic [NUM_CH-1:0]            not_empty;
  logic [NUM_CH-1:0]            pop_vec;
  logic [NUM_CH-1:0][WIDTH-1:0] head;
  logic [IdxW-1:0]              rr_ptr_q, rr_ptr_d, sel;
  logic                         any_valid, pop_fire;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    request_fifo_channel #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .AFULL_THRESH(AFULL_THRESH)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear_en   (bus.clear_en),
      .push_en    (bus.push_en[g]),
      .data_in    (bus.data_in[g]),
      .pop_en     (pop_vec[g]),
      .head       (head[g]),
      .not_empty  (not_empty[g]),
      .full       (bus.full[g]),
      .almost_full(bus.almost_full[g]),
      .overflow   (bus.overflow[g]),
      .count      (bus.count[g])
    );
  end

  // First non-empty channel at or after rr_ptr, scanning with wrap-around.
  always_comb begin
    int unsigned idx;
    sel       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_valid && not_empty[IdxW'(idx)]) begin
        any_valid = 1'b1;
        sel       = IdxW'(idx);
      end
    end
  end

  assign pop_fire = bus.pop_en & any_valid;

  always_comb begin
    bus.empty    = ~any_valid;
    bus.out_ch   = any_valid ? sel : '0;
    bus.data_out = any_valid ? head[sel] : '0;
    pop_vec      = '0;
    if (pop_fire) pop_vec[sel] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (bus.clear_en) begin
      rr_ptr_d = '0;
    end else if (pop_fire) begin
      rr_ptr_d = (sel == IdxW'(NUM_CH - 1)) ? '0 : sel + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: tb/tb_multi_channel_request_fifo.sv
// Directed bench for multi_channel_request_fifo: vector table plus multi-cycle sequences.
module tb_multi_channel_request_fifo;
  import pac_fifo_pkg::*;

  localparam int unsigned W  = 640;
  localparam int unsigned D  = 32;
  localparam int unsigned N  = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  multi_channel_request_fifo_if #(.WIDTH(W), .DEPTH(D), .NUM_CH(N)) bus_if ();

  multi_channel_request_fifo #(
    .WIDTH       (W),
    .DEPTH       (D),
    .NUM_CH      (N),
    .AFULL_THRESH(D - 4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  typedef struct {
    logic [N-1:0]      push;
    logic [15:0]       base;
    logic              pop;
    logic              exp_empty;
    logic [1:0]        exp_ch;
    logic [15:0]       exp_data;
    logic [N-1:0][7:0] exp_cnt;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic [N-1:0] push, input logic [15:0] base, input logic pop,
                              input logic e, input logic [1:0] ch, input logic [15:0] d,
                              input int c0, input int c1, input int c2, input int c3);
    vec_t v;
    v.push = push; v.base = base; v.pop = pop;
    v.exp_empty = e; v.exp_ch = ch; v.exp_data = d;
    v.exp_cnt[0] = 8'(c0); v.exp_cnt[1] = 8'(c1); v.exp_cnt[2] = 8'(c2); v.exp_cnt[3] = 8'(c3);
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.push_en  = '0;
    bus_if.pop_en   = 1'b0;
    bus_if.clear_en = 1'b0;
  endtask

  task automatic push1(input int ch, input logic [W-1:0] d);
    bus_if.push_en     = '0;
    bus_if.push_en[ch] = 1'b1;
    bus_if.data_in[ch] = d;
    tick();
    idle_inputs();
  endtask

  task automatic pop1();
    bus_if.pop_en = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic clear1();
    bus_if.clear_en = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"},    W'(bus_if.empty), W'(1));
    chk({tag, "_data_out"}, bus_if.data_out, '0);
    chk({tag, "_out_ch"},   W'(bus_if.out_ch), '0);
    chk({tag, "_count"},    W'(bus_if.count), '0);
    chk({tag, "_full"},     W'(bus_if.full), '0);
    chk({tag, "_afull"},    W'(bus_if.almost_full), '0);
    chk({tag, "_overflow"}, W'(bus_if.overflow), '0);
  endtask

  logic [W-1:0] q [$];

  initial begin
    bus_if.data_in = '0;
    idle_inputs();

    // Round-robin table; starts from a freshly reset module (rr_ptr = 0).
    tbl[0] = mk(4'b1101, 16'h00A0, 1'b0, 1'b0, 2'd0, 16'h00A0, 1, 0, 1, 1);
    tbl[1] = mk(4'b0000, 16'h0000, 1'b1, 1'b0, 2'd2, 16'h00A2, 0, 0, 1, 1);
    tbl[2] = mk(4'b0000, 16'h0000, 1'b1, 1'b0, 2'd3, 16'h00A3, 0, 0, 0, 1);
    tbl[3] = mk(4'b0000, 16'h0000, 1'b1, 1'b1, 2'd0, 16'h0000, 0, 0, 0, 0);
    tbl[4] = mk(4'b0000, 16'h0000, 1'b1, 1'b1, 2'd0, 16'h0000, 0, 0, 0, 0);
    tbl[5] = mk(4'b1010, 16'h00B0, 1'b0, 1'b0, 2'd1, 16'h00B1, 0, 1, 0, 1);
    tbl[6] = mk(4'b0000, 16'h0000, 1'b0, 1'b0, 2'd1, 16'h00B1, 0, 1, 0, 1);
    tbl[7] = mk(4'b0010, 16'h00C0, 1'b1, 1'b0, 2'd3, 16'h00B3, 0, 1, 0, 1);
    tbl[8] = mk(4'b0000, 16'h0000, 1'b1, 1'b0, 2'd1, 16'h00C1, 0, 1, 0, 0);
    tbl[9] = mk(4'b0000, 16'h0000, 1'b1, 1'b1, 2'd0, 16'h0000, 0, 0, 0, 0);

    #12;
    chk_idle("reset");
    @(negedge clk) reset_n = 1'b1;
    tick();
    chk_idle("post_reset");

    // Fill ch0 to full with random payloads, then drain in order.
    for (int i = 0; i < 32; i++) begin
      logic [W-1:0] d;
      d = W'({$urandom(), $urandom()});
      q.push_back(d);
      push1(0, d);
      if (i == 26) chk("fill_afull_27", W'(bus_if.almost_full[0]), W'(0));
      if (i == 27) chk("fill_afull_28", W'(bus_if.almost_full[0]), W'(1));
      if (i == 30) chk("fill_full_31", W'(bus_if.full[0]), W'(0));
    end
    chk("fill_full_32", W'(bus_if.full[0]), W'(1));
    chk("fill_count_32", W'(bus_if.count[0]), W'(32));
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("drain_data_%0d", i), bus_if.data_out, q[i]);
      chk($sformatf("drain_ch_%0d", i), W'(bus_if.out_ch), W'(0));
      pop1();
    end
    chk("drain_empty", W'(bus_if.empty), W'(1));

    // Overflow on ch1, including a rejected push while ch1 is being popped.
    for (int i = 0; i < 32; i++) push1(1, W'(32'h100 + i));
    push1(1, W'(32'hDEAD));
    chk("ovf_flag", W'(bus_if.overflow), W'(4'b0010));
    chk("ovf_count", W'(bus_if.count[1]), W'(32));
    chk("ovf_head", bus_if.data_out, W'(32'h100));
    chk("ovf_ch", W'(bus_if.out_ch), W'(1));
    bus_if.push_en     = 4'b0010;
    bus_if.data_in[1]  = W'(32'hBEEF);
    bus_if.pop_en      = 1'b1;
    tick();
    idle_inputs();
    chk("ovf_pop_count", W'(bus_if.count[1]), W'(31));
    chk("ovf_pop_head", bus_if.data_out, W'(32'h101));
    chk("ovf_pop_flag", W'(bus_if.overflow), W'(4'b0010));

    // Clear wins over same-cycle push and pop, and drops the overflow flag.
    for (int i = 0; i < 10; i++) push1(2, W'(32'h200 + i));
    chk("pre_clear_count2", W'(bus_if.count[2]), W'(10));
    bus_if.clear_en = 1'b1;
    bus_if.push_en  = 4'b1111;
    bus_if.pop_en   = 1'b1;
    for (int c = 0; c < 4; c++) bus_if.data_in[c] = W'(32'h999);
    tick();
    idle_inputs();
    chk_idle("clear");
    push1(3, W'(32'h333));
    chk("post_clear_ch", W'(bus_if.out_ch), W'(3));
    chk("post_clear_data", bus_if.data_out, W'(32'h333));
    chk("post_clear_count3", W'(bus_if.count[3]), W'(1));
    clear1();

    // Same-channel push and pop at count 5 keeps occupancy and order.
    for (int i = 0; i < 5; i++) push1(0, W'(32'h500 + i));
    bus_if.push_en    = 4'b0001;
    bus_if.data_in[0] = W'(32'h505);
    bus_if.pop_en     = 1'b1;
    tick();
    idle_inputs();
    chk("pp_count", W'(bus_if.count[0]), W'(5));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pp_data_%0d", i), bus_if.data_out, W'(32'h501 + i));
      pop1();
    end
    chk("pp_empty", W'(bus_if.empty), W'(1));
    for (int i = 0; i < 27; i++) push1(0, W'(i));
    chk("af_27", W'(bus_if.almost_full[0]), W'(0));
    push1(0, W'(27));
    chk("af_28", W'(bus_if.almost_full[0]), W'(1));
    chk("af_28_full", W'(bus_if.full[0]), W'(0));
    chk("af_28_count", W'(bus_if.count[0]), W'(28));
    clear1();

    // Reset mid-stream acts before the next clock edge.
    push1(0, W'(32'h77));
    push1(2, W'(32'h88));
    chk("pre_rst_empty", W'(bus_if.empty), W'(0));
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge clk) reset_n = 1'b1;
    tick();

    for (int r = 0; r < 10; r++) begin
      bus_if.push_en = tbl[r].push;
      for (int c = 0; c < 4; c++) bus_if.data_in[c] = W'(tbl[r].base + 16'(c));
      bus_if.pop_en = tbl[r].pop;
      tick();
      idle_inputs();
      chk($sformatf("row%0d_empty", r), W'(bus_if.empty), W'(tbl[r].exp_empty));
      chk($sformatf("row%0d_ch", r), W'(bus_if.out_ch), W'(tbl[r].exp_ch));
      chk($sformatf("row%0d_data", r), bus_if.data_out, W'(tbl[r].exp_data));
      for (int c = 0; c < 4; c++)
        chk($sformatf("row%0d_count%0d", r, c), W'(bus_if.count[c]), W'(tbl[r].exp_cnt[c]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
